// File: rtl/store_buffer_pkg.sv
// Shared store-buffer types: access size encoding and the per-entry record.
// Pure declarations, no logic or latency.
// No flow control here; consumers own their handshakes.
package store_buffer_pkg;

  // Tag width shared with the ROB and the reservation stations.
  localparam int SB_TAG_WIDTH = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // One buffered store. While an operand is not ready, the low tag bits
  // of its value field hold the producer tag rather than a value.
  typedef struct packed {
    logic        valid;
    logic        committed;
    logic [31:0] base;
    logic        base_rdy;
    logic [31:0] data;
    logic        data_rdy;
    logic [31:0] imm;
    mem_size_e   size;
  } store_entry_t;

  // Effective address wraps modulo 2^32.
  function automatic logic [31:0] eff_addr(input logic [31:0] base,
                                           input logic [31:0] imm);
    return base + imm;
  endfunction

endpackage

// File: rtl/store_buffer_operand_snoop.sv
// CDB tag match and capture for one pending store operand.
// Purely combinational; the result is registered by the owning entry.
// No backpressure; the CDB is a broadcast that is never stalled.
module store_buffer_operand_snoop #(
  parameter int TAG_WIDTH = 3
) (
  input  logic [31:0]          val_i,
  input  logic                 rdy_i,
  input  logic                 cdb_valid_i,
  input  logic [TAG_WIDTH-1:0] cdb_tag_i,
  input  logic [31:0]          cdb_data_i,
  output logic [31:0]          val_o,
  output logic                 rdy_o
);

  logic hit;

  // A waiting operand keeps its producer tag in the low bits of its value.
  assign hit   = !rdy_i && cdb_valid_i && (val_i[TAG_WIDTH-1:0] == cdb_tag_i);
  assign val_o = hit ? cdb_data_i : val_i;
  assign rdy_o = rdy_i | hit;

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: allocate, resolve operands from CDB, commit, drain.
// Write request rises on the 2nd edge after commit; one-cycle gap after each accept.
// Alloc dropped when full; mem_* payload held stable until mem_ready_in.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = SB_TAG_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_input_in,
  input  logic [TAG_WIDTH-1:0] rob_ix_in,
  input  logic [31:0]          base_in,
  input  logic                 base_valid_in,
  input  logic [31:0]          data_in,
  input  logic                 data_valid_in,
  input  logic [31:0]          imm_in,
  input  logic [1:0]           size_in,
  output logic                 full_out,
  output logic                 empty_out,
  input  logic                 cdb_valid_in,
  input  logic [TAG_WIDTH-1:0] cdb_tag_in,
  input  logic [31:0]          cdb_data_in,
  output logic                 commit_ready_out,
  output logic [TAG_WIDTH-1:0] commit_rob_ix_out,
  input  logic                 commit_valid_in,
  input  logic [TAG_WIDTH-1:0] commit_rob_ix_in,
  input  logic                 flush_in,
  output logic                 mem_valid_out,
  input  logic                 mem_ready_in,
  output logic [31:0]          mem_addr_out,
  output logic [31:0]          mem_data_out,
  output logic [1:0]           mem_size_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t         ent_q [DEPTH];
  store_entry_t         ent_d [DEPTH];
  logic [TAG_WIDTH-1:0] rob_q [DEPTH];
  logic [TAG_WIDTH-1:0] rob_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ncomm;

  logic          mem_valid_q, mem_valid_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic [1:0]    mem_size_q, mem_size_d;

  logic [31:0]   snp_base_val [DEPTH];
  logic          snp_base_rdy [DEPTH];
  logic [31:0]   snp_data_val [DEPTH];
  logic          snp_data_rdy [DEPTH];
  logic [31:0]   new_base_val, new_data_val;
  logic          new_base_rdy, new_data_rdy;

  logic          pop, do_alloc, do_commit;

  // Resident entries watch the CDB for their outstanding operands.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    store_buffer_operand_snoop #(.TAG_WIDTH(TAG_WIDTH)) u_base (
      .val_i(ent_q[gi].base), .rdy_i(ent_q[gi].base_rdy),
      .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
      .val_o(snp_base_val[gi]), .rdy_o(snp_base_rdy[gi])
    );
    store_buffer_operand_snoop #(.TAG_WIDTH(TAG_WIDTH)) u_data (
      .val_i(ent_q[gi].data), .rdy_i(ent_q[gi].data_rdy),
      .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
      .val_o(snp_data_val[gi]), .rdy_o(snp_data_rdy[gi])
    );
  end

  // The store being allocated also sees a same-cycle CDB broadcast.
  store_buffer_operand_snoop #(.TAG_WIDTH(TAG_WIDTH)) u_new_base (
    .val_i(base_in), .rdy_i(base_valid_in),
    .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
    .val_o(new_base_val), .rdy_o(new_base_rdy)
  );
  store_buffer_operand_snoop #(.TAG_WIDTH(TAG_WIDTH)) u_new_data (
    .val_i(data_in), .rdy_i(data_valid_in),
    .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
    .val_o(new_data_val), .rdy_o(new_data_rdy)
  );

  assign full_out          = (count_q == CW'(DEPTH));
  assign empty_out         = (count_q == '0);
  assign commit_ready_out  = ent_q[cptr_q].valid && !ent_q[cptr_q].committed &&
                             ent_q[cptr_q].base_rdy && ent_q[cptr_q].data_rdy;
  assign commit_rob_ix_out = rob_q[cptr_q];
  assign mem_valid_out     = mem_valid_q;
  assign mem_addr_out      = mem_addr_q;
  assign mem_data_out      = mem_data_q;
  assign mem_size_out      = mem_size_q;

  assign pop       = mem_valid_q && mem_ready_in;
  assign do_alloc  = valid_input_in && !full_out && !flush_in;
  assign do_commit = commit_valid_in && commit_ready_out && !flush_in &&
                     (commit_rob_ix_in == rob_q[cptr_q]);

  // Next-state for entries, pointers, occupancy and the drain request.
  always_comb begin
    ent_d       = ent_q;
    rob_d       = rob_q;
    head_d      = head_q;
    cptr_d      = cptr_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ncomm       = '0;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_size_d  = mem_size_q;

    for (int i = 0; i < DEPTH; i++) begin
      ncomm = ncomm + CW'(ent_q[i].valid & ent_q[i].committed);
      if (ent_q[i].valid) begin
        ent_d[i].base     = snp_base_val[i];
        ent_d[i].base_rdy = snp_base_rdy[i];
        ent_d[i].data     = snp_data_val[i];
        ent_d[i].data_rdy = snp_data_rdy[i];
      end
    end

    if (pop) begin
      ent_d[head_q].valid     = 1'b0;
      ent_d[head_q].committed = 1'b0;
      head_d                  = head_q + PW'(1);
    end

    if (flush_in) begin
      // Committed stores form the run head..cptr; everything younger dies.
      for (int i = 0; i < DEPTH; i++) begin
        if (!ent_q[i].committed) ent_d[i].valid = 1'b0;
      end
      tail_d  = cptr_q;
      count_d = ncomm - CW'(pop);
    end else begin
      if (do_commit) begin
        ent_d[cptr_q].committed = 1'b1;
        cptr_d                  = cptr_q + PW'(1);
      end
      if (do_alloc) begin
        ent_d[tail_q] = '{valid: 1'b1, committed: 1'b0,
                          base: new_base_val, base_rdy: new_base_rdy,
                          data: new_data_val, data_rdy: new_data_rdy,
                          imm: imm_in, size: mem_size_e'(size_in)};
        rob_d[tail_q] = rob_ix_in;
        tail_d        = tail_q + PW'(1);
      end
      count_d = count_q + CW'(do_alloc) - CW'(pop);
    end

    // Drop valid for a cycle after each accept so head_q settles first.
    if (pop) begin
      mem_valid_d = 1'b0;
    end else if (!mem_valid_q && ent_q[head_q].valid && ent_q[head_q].committed) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = eff_addr(ent_q[head_q].base, ent_q[head_q].imm);
      mem_data_d  = ent_q[head_q].data;
      mem_size_d  = ent_q[head_q].size;
    end
  end

  // State registers; reset abandons any in-flight request.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        rob_q[i] <= '0;
      end
      head_q      <= '0;
      cptr_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_size_q  <= '0;
    end else begin
      ent_q       <= ent_d;
      rob_q       <= rob_d;
      head_q      <= head_d;
      cptr_q      <= cptr_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_size_q  <= mem_size_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random bench for store_buffer against a queue-based store model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int TW    = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          valid_input_in;
  logic [TW-1:0] rob_ix_in;
  logic [31:0]   base_in;
  logic          base_valid_in;
  logic [31:0]   data_in;
  logic          data_valid_in;
  logic [31:0]   imm_in;
  logic [1:0]    size_in;
  logic          full_out, empty_out;
  logic          cdb_valid_in;
  logic [TW-1:0] cdb_tag_in;
  logic [31:0]   cdb_data_in;
  logic          commit_ready_out;
  logic [TW-1:0] commit_rob_ix_out;
  logic          commit_valid_in;
  logic [TW-1:0] commit_rob_ix_in;
  logic          flush_in;
  logic          mem_valid_out;
  logic          mem_ready_in;
  logic [31:0]   mem_addr_out, mem_data_out;
  logic [1:0]    mem_size_out;

  store_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .valid_input_in(valid_input_in), .rob_ix_in(rob_ix_in),
    .base_in(base_in), .base_valid_in(base_valid_in),
    .data_in(data_in), .data_valid_in(data_valid_in),
    .imm_in(imm_in), .size_in(size_in),
    .full_out(full_out), .empty_out(empty_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .commit_ready_out(commit_ready_out), .commit_rob_ix_out(commit_rob_ix_out),
    .commit_valid_in(commit_valid_in), .commit_rob_ix_in(commit_rob_ix_in),
    .flush_in(flush_in),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_size_out(mem_size_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: stores in program order, oldest first.
  typedef struct {
    logic [TW-1:0] rob;
    logic [31:0]   base;
    bit            brdy;
    logic [31:0]   data;
    bit            drdy;
    logic [31:0]   imm;
    logic [1:0]    size;
    bit            com;
  } m_t;

  m_t q[$];
  int total = 0, bad = 0, nwrites = 0;
  bit chk_en = 0;
  bit prev_v = 0, prev_r = 0, prev_hc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_unc();
    for (int i = 0; i < q.size(); i++) if (!q[i].com) return i;
    return -1;
  endfunction

  function automatic bit m_ready();
    int f;
    f = first_unc();
    return (f >= 0) && q[f].brdy && q[f].drdy;
  endfunction

  // Compare outputs with the model just before the edge.
  task automatic pre_check(output bit hs);
    bit ev, rdy;
    int f;
    ev  = prev_v ? !prev_r : prev_hc;
    rdy = m_ready();
    f   = first_unc();
    if (chk_en) begin
      chk("mem_valid", mem_valid_out, ev);
      if (ev && q.size() > 0) begin
        chk("mem_addr", mem_addr_out, q[0].base + q[0].imm);
        chk("mem_data", mem_data_out, q[0].data);
        chk("mem_size", mem_size_out, q[0].size);
      end
      chk("full", full_out, q.size() == DEPTH);
      chk("empty", empty_out, q.size() == 0);
      chk("commit_ready", commit_ready_out, rdy);
      if (rdy) chk("commit_rob", commit_rob_ix_out, q[f].rob);
    end
    prev_v  = ev;
    prev_r  = mem_ready_in;
    prev_hc = (q.size() > 0) && q[0].com;
    hs      = ev && mem_ready_in;
  endtask

  // Apply one clock of the store rules to the model.
  task automatic model_edge(input bit hs);
    int  f, sz0;
    bit  rdy;
    m_t  n;
    if (rst_in) begin
      q.delete();
      prev_v = 0; prev_r = 0; prev_hc = 0;
      return;
    end
    f   = first_unc();
    rdy = m_ready();
    sz0 = q.size();
    if (cdb_valid_in) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].brdy && q[i].base[TW-1:0] == cdb_tag_in) begin q[i].base = cdb_data_in; q[i].brdy = 1; end
        if (!q[i].drdy && q[i].data[TW-1:0] == cdb_tag_in) begin q[i].data = cdb_data_in; q[i].drdy = 1; end
      end
    end
    if (flush_in) begin
      while (q.size() > 0 && !q[q.size()-1].com) void'(q.pop_back());
    end else begin
      if (commit_valid_in && rdy && commit_rob_ix_in == q[f].rob) q[f].com = 1;
      if (valid_input_in && sz0 < DEPTH) begin
        n.rob  = rob_ix_in;
        n.imm  = imm_in;
        n.size = size_in;
        n.com  = 0;
        n.brdy = base_valid_in || (cdb_valid_in && base_in[TW-1:0] == cdb_tag_in);
        n.base = (!base_valid_in && n.brdy) ? cdb_data_in : base_in;
        n.drdy = data_valid_in || (cdb_valid_in && data_in[TW-1:0] == cdb_tag_in);
        n.data = (!data_valid_in && n.drdy) ? cdb_data_in : data_in;
        q.push_back(n);
      end
    end
    if (hs && q.size() > 0) begin
      void'(q.pop_front());
      nwrites++;
    end
  endtask

  task automatic tick();
    bit hs;
    #4;
    pre_check(hs);
    @(posedge clk_in);
    model_edge(hs);
    #1;
  endtask

  task automatic idle();
    valid_input_in = 0; rob_ix_in = '0; base_in = '0; base_valid_in = 0;
    data_in = '0; data_valid_in = 0; imm_in = '0; size_in = '0;
    cdb_valid_in = 0; cdb_tag_in = '0; cdb_data_in = '0;
    commit_valid_in = 0; commit_rob_ix_in = '0; flush_in = 0;
  endtask

  task automatic set_alloc(input logic [TW-1:0] rob, input logic [31:0] b, input bit bv,
                           input logic [31:0] d, input bit dv, input logic [31:0] imm,
                           input logic [1:0] sz);
    valid_input_in = 1; rob_ix_in = rob; base_in = b; base_valid_in = bv;
    data_in = d; data_valid_in = dv; imm_in = imm; size_in = sz;
  endtask

  task automatic do_commit(input logic [TW-1:0] rob);
    commit_valid_in = 1; commit_rob_ix_in = rob;
    tick();
    idle();
  endtask

  task automatic wait_mv();
    for (int k = 0; k < 20 && !mem_valid_out; k++) tick();
    chk("wait_mem_valid", mem_valid_out, 1);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 60 && !empty_out; k++) tick();
    chk("wait_empty", empty_out, 1);
  endtask

  initial begin
    int f, nw;
    logic [31:0] a0, d0;
    idle();
    rst_in = 1; mem_ready_in = 0;
    tick(); tick();
    rst_in = 0; chk_en = 1;

    chk("rst_full", full_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_commit_ready", commit_ready_out, 0);
    chk("rst_mem_valid", mem_valid_out, 0);
    chk("rst_mem_addr", mem_addr_out, 0);
    chk("rst_mem_data", mem_data_out, 0);
    chk("rst_mem_size", mem_size_out, 0);
    chk("rst_commit_rob", commit_rob_ix_out, 0);

    // Basic store: word at 0x100+4.
    set_alloc(3'd2, 32'h100, 1, 32'hAB, 1, 32'd4, 2'd2); tick(); idle();
    chk("t1_commit_ready", commit_ready_out, 1);
    chk("t1_commit_rob", commit_rob_ix_out, 2);
    do_commit(3'd2);
    chk("t1_mv_first_edge", mem_valid_out, 0);
    tick();
    chk("t1_mv_second_edge", mem_valid_out, 1);
    chk("t1_addr", mem_addr_out, 32'h104);
    chk("t1_data", mem_data_out, 32'hAB);
    chk("t1_size", mem_size_out, 2);
    mem_ready_in = 1; tick(); mem_ready_in = 0;
    chk("t1_empty", empty_out, 1);

    // Data arrives on the CDB the cycle after allocation.
    set_alloc(3'd1, 32'h300, 1, 32'd5, 0, 32'd0, 2'd2); tick(); idle();
    chk("t2_not_ready", commit_ready_out, 0);
    cdb_valid_in = 1; cdb_tag_in = 3'd5; cdb_data_in = 32'hDEAD; tick(); idle();
    chk("t2_ready", commit_ready_out, 1);
    do_commit(3'd1); tick();
    chk("t2_data", mem_data_out, 32'hDEAD);
    mem_ready_in = 1; tick(); mem_ready_in = 0;

    // Base resolves on the CDB in the allocation cycle itself.
    set_alloc(3'd4, 32'd3, 0, 32'h55, 1, 32'h10, 2'd0);
    cdb_valid_in = 1; cdb_tag_in = 3'd3; cdb_data_in = 32'h200; tick(); idle();
    chk("t3_ready", commit_ready_out, 1);
    do_commit(3'd4); tick();
    chk("t3_addr", mem_addr_out, 32'h210);
    mem_ready_in = 1; tick(); mem_ready_in = 0;

    // Fill, overflow attempt, then drain four writes in order.
    for (int i = 0; i < 4; i++) begin
      set_alloc(TW'(i), 32'h1000 + 32'(i) * 32'h10, 1, 32'(i) + 32'h70, 1, 32'd0, 2'd1);
      tick();
    end
    chk("t4_full", full_out, 1);
    set_alloc(3'd7, 32'h9999, 1, 32'h1, 1, 32'd0, 2'd2); tick(); idle();
    chk("t4_still_full", full_out, 1);
    nw = nwrites;
    for (int i = 0; i < 4; i++) do_commit(TW'(i));
    mem_ready_in = 1; wait_empty(); mem_ready_in = 0;
    chk("t4_writes", nwrites - nw, 4);

    // Commit one of three, flush the rest.
    for (int i = 4; i < 7; i++) begin
      set_alloc(TW'(i), 32'h2000 + 32'(i), 1, 32'(i), 1, 32'd8, 2'd2);
      tick();
    end
    idle();
    nw = nwrites;
    do_commit(3'd4);
    flush_in = 1; tick(); idle();
    set_alloc(3'd7, 32'h40, 1, 32'h41, 1, 32'd0, 2'd0); tick(); idle();
    chk("t5_realloc_ready", commit_ready_out, 1);
    chk("t5_realloc_rob", commit_rob_ix_out, 7);
    flush_in = 1; tick(); idle();
    mem_ready_in = 1; wait_empty(); mem_ready_in = 0;
    chk("t5_writes", nwrites - nw, 1);
    chk("t5_empty", empty_out, 1);

    // Five-cycle stall keeps the payload stable; exactly one write.
    set_alloc(3'd1, 32'h500, 1, 32'hC0FFEE, 1, 32'hC, 2'd2); tick(); idle();
    do_commit(3'd1);
    wait_mv();
    a0 = mem_addr_out; d0 = mem_data_out;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_stall_valid", mem_valid_out, 1);
      chk("t6_stall_addr", mem_addr_out, a0);
      chk("t6_stall_data", mem_data_out, d0);
    end
    nw = nwrites;
    mem_ready_in = 1; tick(); mem_ready_in = 0;
    chk("t6_one_write", nwrites - nw, 1);
    chk("t6_drop", mem_valid_out, 0);

    // Reset in the middle of a drain.
    set_alloc(3'd2, 32'h600, 1, 32'h66, 1, 32'd0, 2'd2); tick(); idle();
    do_commit(3'd2);
    wait_mv();
    rst_in = 1; tick(); rst_in = 0;
    chk("t6_rst_mv", mem_valid_out, 0);
    chk("t6_rst_empty", empty_out, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      f = first_unc();
      valid_input_in   = 1'($urandom_range(0, 1));
      rob_ix_in        = TW'($urandom);
      base_in          = $urandom;
      base_valid_in    = ($urandom_range(0, 2) != 0);
      data_in          = $urandom;
      data_valid_in    = ($urandom_range(0, 2) != 0);
      imm_in           = $urandom;
      size_in          = 2'($urandom_range(0, 2));
      cdb_valid_in     = ($urandom_range(0, 4) < 2);
      cdb_tag_in       = TW'($urandom);
      cdb_data_in      = $urandom;
      commit_valid_in  = ($urandom_range(0, 2) != 0);
      commit_rob_ix_in = (f >= 0 && $urandom_range(0, 3) != 0) ? q[f].rob : TW'($urandom);
      flush_in         = ($urandom_range(0, 49) == 0);
      mem_ready_in     = ($urandom_range(0, 4) < 3);
      tick();
    end

    idle();
    flush_in = 1; tick(); idle();
    mem_ready_in = 1; wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
